// File: rtl/seq_alu_byteserial.sv
// Byte-serial multi-cycle ALU: WIDTH-bit operands A and B, then an opcode byte,
// arrive over an 8-bit valid/ready channel. The result goes back little-endian
// over an 8-bit valid/ready channel, with carry/zero/err flags alongside.
// Optional feature macro: SEQ_ALU_MUL_EN adds an iterative shift-add MUL (op 7).
module seq_alu_byteserial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       flag_carry,
  output logic       flag_zero,
  output logic       flag_err,
  output logic       busy
);

  localparam int unsigned NB  = WIDTH / 8;
  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned BCW = 4;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, OUT_STATE} state_t;

  state_t           state, next_state;
  logic [BCW-1:0]   byte_cnt, byte_nxt;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic             in_fire, out_fire, last_byte, exec_done;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_e;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   shr_w;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign byte_nxt  = byte_cnt + BCW'(1);
  assign shamt     = b_q[SW-1:0];

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MCW = 7;

  logic [PW-1:0]    mul_acc, mul_mcand, mul_next;
  logic [WIDTH-1:0] mul_mplier;
  logic [MCW-1:0]   mul_cnt;
  logic             mul_last;

  assign mul_next  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last  = (mul_cnt == MCW'(WIDTH - 1));
  assign exec_done = (op_q != 3'd7) || mul_last;

  // Shift-add multiplier: one multiplier bit per EXEC cycle, armed on the opcode beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (state == LOAD_OP && in_fire) begin
      mul_acc    <= '0;
      mul_mcand  <= PW'(a_q);
      mul_mplier <= b_q;
      mul_cnt    <= '0;
    end else if (state == EXEC) begin
      mul_acc    <= mul_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + MCW'(1);
    end
  end
`else
  assign exec_done = 1'b1;
`endif

  // Single-cycle result and flags for the latched opcode
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_e = 1'b0;
    shr_w = '0;
    case (op_q)
      3'd0: {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
      3'd1: begin
        alu_r = a_q - b_q;
        alu_c = (a_q < b_q);
      end
      3'd2: alu_r = a_q & b_q;
      3'd3: alu_r = a_q | b_q;
      3'd4: alu_r = a_q ^ b_q;
      // Extra bit above/below the operand catches the last bit shifted out
      3'd5: {alu_c, alu_r} = {1'b0, a_q} << shamt;
      3'd6: begin
        shr_w = {a_q, 1'b0} >> shamt;
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      default: begin
`ifdef SEQ_ALU_MUL_EN
        alu_r = mul_next[WIDTH-1:0];
        alu_c = |mul_next[PW-1:WIDTH];
`else
        alu_e = 1'b1;
`endif
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      LOAD_A:    if (in_fire && last_byte) next_state = LOAD_B;
      LOAD_B:    if (in_fire && last_byte) next_state = LOAD_OP;
      LOAD_OP:   if (in_fire) next_state = EXEC;
      EXEC:      if (exec_done) next_state = OUT_STATE;
      OUT_STATE: if (out_fire && last_byte) next_state = LOAD_A;
      default:   next_state = LOAD_A;
    endcase
  end

  // Operand capture, result/flag latch and byte-serial output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      flag_err   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      in_ready <= (next_state == LOAD_A) || (next_state == LOAD_B) ||
                  (next_state == LOAD_OP);
      busy     <= (next_state != LOAD_A);
      case (state)
        LOAD_A: if (in_fire) begin
          a_q[{byte_cnt, 3'b000} +: 8] <= in_data;
          byte_cnt <= last_byte ? '0 : byte_nxt;
        end
        LOAD_B: if (in_fire) begin
          b_q[{byte_cnt, 3'b000} +: 8] <= in_data;
          byte_cnt <= last_byte ? '0 : byte_nxt;
        end
        LOAD_OP: if (in_fire) op_q <= in_data[2:0];
        EXEC: if (exec_done) begin
          result_q   <= alu_r;
          flag_carry <= alu_c;
          flag_zero  <= (alu_r == '0);
          flag_err   <= alu_e;
        end
        OUT_STATE: begin
          // First cycle presents byte 0; later bytes advance on each accepted beat
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result_q[7:0];
          end else if (out_ready) begin
            if (last_byte) begin
              out_valid <= 1'b0;
              byte_cnt  <= '0;
            end else begin
              byte_cnt <= byte_nxt;
              out_data <= result_q[{byte_nxt, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_byteserial.sv
// Directed bench for seq_alu_byteserial (WIDTH=16) with an arithmetic reference model
// and a per-cycle output monitor.
module tb_seq_alu_byteserial;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NB    = WIDTH / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flag_carry, flag_zero, flag_err, busy;

  seq_alu_byteserial #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_err(flag_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
    logic       e;
  } beat_t;

  int         total = 0;
  int         bad   = 0;
  beat_t      exp_q[$];
  logic [7:0] rx_q[$];

`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = 17;
  localparam logic [15:0] MUL_RX = 16'h0001;
  localparam logic [18:0] MUL_PIN = {3'b001, 16'h0100};
`else
  localparam int MUL_LAT = 2;
  localparam logic [15:0] MUL_RX = 16'h0000;
  localparam logic [18:0] MUL_PIN = {3'b110, 16'h0000};
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Reference: returns {err, zero, carry, result}
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [2:0] op);
    logic [WIDTH-1:0] r;
    logic             c, e;
    logic [63:0]      wide;
    int               s;
    r = '0; c = 1'b0; e = 1'b0; wide = '0;
    s = int'(b) % int'(WIDTH);
    case (op)
      3'd0: begin wide = 64'(a) + 64'(b); r = wide[WIDTH-1:0]; c = wide[WIDTH]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << s; c = (s == 0) ? 1'b0 : a[WIDTH-s]; end
      3'd6: begin r = a >> s; c = (s == 0) ? 1'b0 : a[s-1]; end
      default: begin
`ifdef SEQ_ALU_MUL_EN
        wide = 64'(a) * 64'(b);
        r = wide[WIDTH-1:0];
        c = |wide[2*WIDTH-1:WIDTH];
`else
        e = 1'b1;
`endif
      end
    endcase
    return {e, (r == '0), c, r};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: byte %0h not accepted", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb);
    logic [WIDTH+2:0] m;
    beat_t            bt;
    m = model(a, b, opb[2:0]);
    for (int i = 0; i < int'(NB); i++) begin
      bt.d = m[8*i +: 8];
      bt.c = m[WIDTH];
      bt.z = m[WIDTH+1];
      bt.e = m[WIDTH+2];
      exp_q.push_back(bt);
    end
    for (int i = 0; i < int'(NB); i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < int'(NB); i++) send_byte(b[8*i +: 8]);
    send_byte(opb);
  endtask

  task automatic run_cmd(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] opb, input logic [15:0] exp_rx, input int exp_lat);
    int n;
    rx_q.delete();
    send_cmd(a, b, opb);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_bytes"}, {rx_q[0], rx_q[1]}, 64'(exp_rx));
  endtask

  initial begin
    logic [WIDTH+2:0] m;
    int               n;

    // Output monitor: every valid beat must match the model's queued expectation
    fork
      begin : monitor
        beat_t e;
        forever begin
          @(negedge clk);
          if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
              chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
              e = exp_q[0];
              chk("out_beat", {out_data, flag_carry, flag_zero, flag_err}, {e.d, e.c, e.z, e.e});
              if (out_ready) begin
                rx_q.push_back(out_data);
                void'(exp_q.pop_front());
              end
            end
            chk("no_input_during_output", 64'(in_ready), 64'd0);
          end
        end
      end
    join_none

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {in_ready, out_valid, out_data, flag_carry, flag_zero, flag_err, busy},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model itself with hand-computed values
    chk("model_add", model(16'h1234, 16'h0F0F, 3'd0), {3'b000, 16'h2143});
    chk("model_sub", model(16'h0001, 16'h0002, 3'd1), {3'b001, 16'hFFFF});
    chk("model_xor", model(16'h5A5A, 16'h5A5A, 3'd4), {3'b010, 16'h0000});
    chk("model_shl", model(16'h8001, 16'h0001, 3'd5), {3'b001, 16'h0002});
    chk("model_shr", model(16'h8001, 16'h0001, 3'd6), {3'b001, 16'h4000});
    chk("model_op7", model(16'h0100, 16'h0101, 3'd7), 64'(MUL_PIN));

    run_cmd("add",      16'h1234, 16'h0F0F, 8'h00, 16'h4321, 2);
    run_cmd("sub_uf",   16'h0001, 16'h0002, 8'h01, 16'hFFFF, 2);
    run_cmd("xor_zero", 16'h5A5A, 16'h5A5A, 8'h04, 16'h0000, 2);
    run_cmd("shl",      16'h8001, 16'h0001, 8'h05, 16'h0200, 2);
    run_cmd("shr",      16'h8001, 16'h0001, 8'h06, 16'h0040, 2);
    run_cmd("shl_zero", 16'h00F0, 16'h0010, 8'h05, 16'hF000, 2);
    run_cmd("and",      16'hF0F0, 16'hFF00, 8'h02, 16'h00F0, 2);
    run_cmd("add_hiop", 16'hFFFF, 16'h0001, 8'hF8, 16'h0000, 2);
    run_cmd("op7",      16'h0100, 16'h0101, 8'h07, MUL_RX, MUL_LAT);

    // Backpressure on the first result byte
    out_ready = 1'b0;
    rx_q.delete();
    send_cmd(16'hABCD, 16'h1111, 8'h00);
    m = model(16'hABCD, 16'h1111, 3'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_data, out_valid, flag_carry, flag_zero, flag_err, in_ready},
          {m[7:0], 1'b1, m[WIDTH], m[WIDTH+1], m[WIDTH+2], 1'b0});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_mid", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_bytes", {rx_q[0], rx_q[1]}, 64'h00DEBC);

    // Asynchronous reset in the middle of loading operands
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    chk("busy_mid_load", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {in_ready, busy, out_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_cmd("post_rst_add", 16'h1111, 16'h2222, 8'h00, 16'h3333, 2);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
